// File: rtl/cash_accumulator.sv
// Coin front end for the vending core: accumulates coin credit, forwards it as cash,
// and pays back change or the full credit through a valid/ack refund handshake.
module cash_accumulator #(
  parameter int unsigned CASH_W   = 6,
  parameter int unsigned MAX_CASH = 63,
  parameter int unsigned TIMEOUT  = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              coin_valid,
  input  logic [1:0]        coin_type,
  input  logic              cancel,
  input  logic              vend_done,
  input  logic [CASH_W-1:0] balance_in,
  input  logic              refund_ack,
  output logic [CASH_W-1:0] cash,
  output logic              coin_reject,
  output logic              refund_valid,
  output logic [CASH_W-1:0] refund_amount,
  output logic              busy
);

  typedef enum logic [1:0] {StIdle, StCollect, StRefund} state_e;

  localparam logic [CASH_W:0] MaxSum    = (CASH_W+1)'(MAX_CASH);
  localparam logic [7:0]      TimeoutCy = 8'(TIMEOUT);

  state_e            state_q, state_d;
  logic [CASH_W-1:0] cash_q, cash_d;
  logic [CASH_W-1:0] amount_q, amount_d;
  logic [7:0]        timer_q, timer_d;
  logic              reject_q, reject_d;
  logic              valid_q, valid_d;
  logic              busy_q, busy_d;
  logic [CASH_W:0]   coin_val;
  logic [CASH_W:0]   sum;

  always_comb begin
    coin_val = '0;
    unique case (coin_type)
      2'b00: coin_val = (CASH_W+1)'(1);
      2'b01: coin_val = (CASH_W+1)'(2);
      2'b10: coin_val = (CASH_W+1)'(5);
      2'b11: coin_val = (CASH_W+1)'(10);
      default: coin_val = '0;
    endcase
  end

  // One bit wider than cash so an overflowing coin is detected instead of wrapping.
  assign sum = {1'b0, cash_q} + coin_val;

  always_comb begin
    state_d  = state_q;
    cash_d   = cash_q;
    amount_d = amount_q;
    timer_d  = timer_q;
    reject_d = 1'b0;
    valid_d  = valid_q;

    unique case (state_q)
      StIdle: begin
        cash_d = '0;
        if (coin_valid) begin
          if (coin_val <= MaxSum) begin
            cash_d  = coin_val[CASH_W-1:0];
            timer_d = '0;
            state_d = StCollect;
          end else begin
            reject_d = 1'b1;
          end
        end
      end

      StCollect: begin
        if (vend_done) begin
          reject_d = coin_valid;
          amount_d = balance_in;
          cash_d   = '0;
          timer_d  = '0;
          if (balance_in != '0) begin
            valid_d = 1'b1;
            state_d = StRefund;
          end else begin
            state_d = StIdle;
          end
        end else if (cancel || (timer_q == TimeoutCy)) begin
          reject_d = coin_valid;
          amount_d = cash_q;
          cash_d   = '0;
          timer_d  = '0;
          valid_d  = 1'b1;
          state_d  = StRefund;
        end else if (coin_valid && (sum <= MaxSum)) begin
          cash_d  = sum[CASH_W-1:0];
          timer_d = '0;
        end else begin
          reject_d = coin_valid;
          if (timer_q != TimeoutCy) begin
            timer_d = timer_q + 8'd1;
          end
        end
      end

      StRefund: begin
        reject_d = coin_valid;
        cash_d   = '0;
        valid_d  = 1'b1;
        if (refund_ack) begin
          valid_d  = 1'b0;
          amount_d = '0;
          state_d  = StIdle;
        end
      end

      default: begin
        state_d  = StIdle;
        cash_d   = '0;
        amount_d = '0;
        timer_d  = '0;
        valid_d  = 1'b0;
      end
    endcase

    busy_d = (state_d == StRefund);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      cash_q   <= '0;
      amount_q <= '0;
      timer_q  <= '0;
      reject_q <= 1'b0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cash_q   <= cash_d;
      amount_q <= amount_d;
      timer_q  <= timer_d;
      reject_q <= reject_d;
      valid_q  <= valid_d;
      busy_q   <= busy_d;
    end
  end

  assign cash          = cash_q;
  assign coin_reject   = reject_q;
  assign refund_valid  = valid_q;
  assign refund_amount = amount_q;
  assign busy          = busy_q;

endmodule
